// File: rtl/gol_vga_renderer.sv
// ============================================================================
// Module      : gol_vga_renderer
// Description : Renders a 16x16 Game of Life board as square cells on a
//               640x480@60 VGA display, using a once-per-frame board snapshot.
//               Optional grid lines and border: GOL_VGA_GRID_LINES_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gol_vga_renderer #(
    parameter int          CLK_DIV     = 4,
    parameter int          CELL_PX     = 24,
    parameter int          X_ORIGIN    = 128,
    parameter int          Y_ORIGIN    = 48,
    parameter logic [11:0] ALIVE_COLOR = 12'hFFF,
    parameter logic [11:0] DEAD_COLOR  = 12'h000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] board_i,
    output logic         hsync_o,
    output logic         vsync_o,
    output logic [11:0]  rgb_o,
    output logic         frame_start_o
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_PX_W  = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_PX_W-1:0]  c_PX_LAST  = c_PX_W'(CELL_PX - 1);

    localparam logic [9:0] c_H_VIS    = 10'd640;
    localparam logic [9:0] c_H_SYNC0  = 10'd656;
    localparam logic [9:0] c_H_SYNC1  = 10'd752;
    localparam logic [9:0] c_H_LAST   = 10'd799;
    localparam logic [9:0] c_V_VIS    = 10'd480;
    localparam logic [9:0] c_V_SYNC0  = 10'd490;
    localparam logic [9:0] c_V_SYNC1  = 10'd492;
    localparam logic [9:0] c_V_LAST   = 10'd524;
    localparam logic [9:0] c_X0       = 10'(X_ORIGIN);
    localparam logic [9:0] c_X1       = 10'(X_ORIGIN + 16 * CELL_PX);
    localparam logic [9:0] c_Y0       = 10'(Y_ORIGIN);
    localparam logic [9:0] c_Y1       = 10'(Y_ORIGIN + 16 * CELL_PX);
    localparam logic [11:0] c_GRID_COLOR = 12'h444;

    logic [c_DIV_W-1:0] r_div;
    logic [9:0]         r_hcnt;
    logic [9:0]         r_vcnt;
    logic [c_PX_W-1:0]  r_px_in_cell;
    logic [c_PX_W-1:0]  r_py_in_cell;
    logic [3:0]         r_cell_x;
    logic [3:0]         r_cell_y;
    logic [255:0]       r_snapshot;
    logic               r_hsync;
    logic               r_vsync;
    logic [11:0]        r_rgb;
    logic               r_frame_start;

    logic        w_tick;
    logic        w_line_end;
    logic [9:0]  w_hcnt_nxt;
    logic [9:0]  w_vcnt_nxt;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_in_board;
    logic        w_blank;
    logic        w_grid;
    logic [7:0]  w_cell_idx;
    logic [11:0] w_rgb;

    assign w_tick     = (r_div == c_DIV_LAST);
    assign w_line_end = (r_hcnt == c_H_LAST);
    assign w_hcnt_nxt = w_line_end ? 10'd0 : r_hcnt + 10'd1;
    assign w_vcnt_nxt = (r_vcnt == c_V_LAST) ? 10'd0 : r_vcnt + 10'd1;
    assign w_in_x     = (r_hcnt >= c_X0) && (r_hcnt < c_X1);
    assign w_in_y     = (r_vcnt >= c_Y0) && (r_vcnt < c_Y1);
    assign w_in_board = w_in_x && w_in_y;
    assign w_blank    = (r_hcnt >= c_H_VIS) || (r_vcnt >= c_V_VIS);
    assign w_cell_idx = {r_cell_y, r_cell_x};

`ifdef GOL_VGA_GRID_LINES_EN
    assign w_grid = (w_in_board && ((r_px_in_cell == '0) || (r_py_in_cell == '0)))
                  || ((r_hcnt == c_X1) && (r_vcnt >= c_Y0) && (r_vcnt <= c_Y1))
                  || ((r_vcnt == c_Y1) && (r_hcnt >= c_X0) && (r_hcnt <= c_X1));
`else
    assign w_grid = 1'b0;
`endif

    // Blanking has priority so the border never leaks into the porches.
    always_comb begin
        w_rgb = DEAD_COLOR;
        if (w_blank) begin
            w_rgb = 12'h000;
        end else if (w_grid) begin
            w_rgb = c_GRID_COLOR;
        end else if (w_in_board && r_snapshot[w_cell_idx]) begin
            w_rgb = ALIVE_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_hcnt <= w_hcnt_nxt;
            if (w_line_end) begin
                r_vcnt <= w_vcnt_nxt;
            end
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Cell counters always hold the position of the pixel currently in hcnt/vcnt;
    // they clear one tick early so the first board pixel sees zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_px_in_cell <= '0;
            r_cell_x     <= '0;
            r_py_in_cell <= '0;
            r_cell_y     <= '0;
        end else if (w_tick) begin
            if (w_hcnt_nxt == c_X0) begin
                r_px_in_cell <= '0;
                r_cell_x     <= '0;
            end else if (w_in_x) begin
                if (r_px_in_cell == c_PX_LAST) begin
                    r_px_in_cell <= '0;
                    r_cell_x     <= r_cell_x + 4'd1;
                end else begin
                    r_px_in_cell <= r_px_in_cell + 1'b1;
                end
            end
            if (w_line_end) begin
                if (w_vcnt_nxt == c_Y0) begin
                    r_py_in_cell <= '0;
                    r_cell_y     <= '0;
                end else if (w_in_y) begin
                    if (r_py_in_cell == c_PX_LAST) begin
                        r_py_in_cell <= '0;
                        r_cell_y     <= r_cell_y + 4'd1;
                    end else begin
                        r_py_in_cell <= r_py_in_cell + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snapshot    <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= 12'h000;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
            if (w_tick) begin
                if ((r_hcnt == 10'd0) && (r_vcnt == c_V_VIS)) begin
                    r_snapshot <= board_i;
                end
                r_hsync <= !((r_hcnt >= c_H_SYNC0) && (r_hcnt < c_H_SYNC1));
                r_vsync <= !((r_vcnt >= c_V_SYNC0) && (r_vcnt < c_V_SYNC1));
                r_rgb   <= w_rgb;
            end
        end
    end

    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign rgb_o         = r_rgb;
    assign frame_start_o = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_gol_vga_renderer.sv
// ============================================================================
// Module      : tb_gol_vga_renderer
// Description : Directed self-checking bench for gol_vga_renderer (CLK_DIV=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gol_vga_renderer;

    localparam int c_DIV   = 2;
    localparam int c_FRAME = 525 * 800 * c_DIV;

    logic         clk;
    logic         reset;
    logic [255:0] board_i;
    logic         hsync_o;
    logic         vsync_o;
    logic [11:0]  rgb_o;
    logic         frame_start_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hl       = 0;
    int vl       = 0;
    int f        = 0;

    gol_vga_renderer #(.CLK_DIV(c_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .board_i       (board_i),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .rgb_o         (rgb_o),
        .frame_start_o (frame_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!hsync_o) hl <= hl + 1;
        if (!vsync_o) vl <= vl + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference colour computed directly from pixel coordinates with division.
    function automatic logic [11:0] exp_rgb(input logic [255:0] s, input int x, input int y);
        bit inb;
        if (x >= 640 || y >= 480) return 12'h000;
        inb = (x >= 128 && x < 512 && y >= 48 && y < 432);
`ifdef GOL_VGA_GRID_LINES_EN
        if (inb && (((x - 128) % 24) == 0 || ((y - 48) % 24) == 0)) return 12'h444;
        if ((x == 512 && y >= 48 && y <= 432) || (y == 432 && x >= 128 && x <= 512)) return 12'h444;
`endif
        if (inb && s[((y - 48) / 24) * 16 + (x - 128) / 24]) return 12'hFFF;
        return 12'h000;
    endfunction

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start_o && n < c_FRAME + 1000);
        if (!frame_start_o) check("fs_timeout", 32'd0, 32'd1);
        f = cyc;
    endtask

    task automatic at_pix(input int x, input int y);
        int target = f + (y * 800 + x) * c_DIV;
        if (cyc > target) check("pix_order", cyc, target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic chk_pix(input string tag, input int x, input int y, input logic [255:0] s);
        at_pix(x, y);
        check(tag, rgb_o, exp_rgb(s, x, y));
    endtask

    initial begin
        logic [255:0] b_old;
        logic [255:0] b_new;
        int f0, fb, hl0, vl0, c_rel;
        b_old = (256'd1) | (256'd1 << 255);
        b_new = (256'd1 << 89) | (256'd1 << 197);

        reset   = 1'b1;
        board_i = '0;
        repeat (10) @(negedge clk);
        check("rst_hsync", hsync_o, 1);
        check("rst_vsync", vsync_o, 1);
        check("rst_rgb", rgb_o, 0);
        check("rst_fs", frame_start_o, 0);

        board_i = b_old;
        reset   = 1'b0;
        c_rel   = cyc;
        @(negedge clk);
        check("fs_early", frame_start_o, 0);
        @(negedge clk);
        check("fs_first", frame_start_o, 1);
        check("fs_lat", cyc - c_rel, 2);
        f  = cyc;
        f0 = f;
        hl0 = hl;
        vl0 = vl;
        @(negedge clk);
        check("fs_width", frame_start_o, 0);

        // Frame A: snapshot still cleared
        at_pix(655, 0); check("hs_655", hsync_o, 1);
        at_pix(656, 0); check("hs_656", hsync_o, 0);
        at_pix(751, 0); check("hs_751", hsync_o, 0);
        at_pix(752, 0); check("hs_752", hsync_o, 1);
        at_pix(0, 1);   check("hs_line_low", hl - hl0, 96 * c_DIV);
        chk_pix("A_128_48", 128, 48, '0);
        chk_pix("A_140_60", 140, 60, '0);
        at_pix(799, 489); check("vs_489", vsync_o, 1);
        at_pix(0, 490);   check("vs_490", vsync_o, 0);
        at_pix(799, 491); check("vs_491", vsync_o, 0);
        at_pix(0, 492);   check("vs_492", vsync_o, 1);

        wait_fs();
        fb = f;
        check("frame_period", fb - f0, c_FRAME);
        check("hs_frame_low", hl - hl0, 525 * 96 * c_DIV);
        check("vs_frame_low", vl - vl0, 2 * 800 * c_DIV);

        // Frame B: bits 0 and 255
        chk_pix("B_127_48", 127, 48, b_old);
        chk_pix("B_128_48", 128, 48, b_old);
        chk_pix("B_129_49", 129, 49, b_old);
        chk_pix("B_151_71", 151, 71, b_old);
        chk_pix("B_152_71", 152, 71, b_old);
        chk_pix("B_151_72", 151, 72, b_old);
        at_pix(0, 200);
        board_i = b_new;
        chk_pix("B_coh_250_340", 250, 340, b_old);
        chk_pix("B_488_408", 488, 408, b_old);
        chk_pix("B_511_431", 511, 431, b_old);
        chk_pix("B_512_431", 512, 431, b_old);
        chk_pix("B_511_432", 511, 432, b_old);

        wait_fs();
        check("frame_period2", f - fb, c_FRAME);

        // Frame C: new board visible, then reset at line 300
        chk_pix("C_128_48", 128, 48, b_new);
        chk_pix("C_350_170", 350, 170, b_new);
        at_pix(0, 300);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        c_rel = cyc;
        check("mid_rst_hsync", hsync_o, 1);
        check("mid_rst_vsync", vsync_o, 1);
        check("mid_rst_rgb", rgb_o, 0);
        wait_fs();
        check("mid_rst_fs_lat", cyc - c_rel, 2);

        // Frame D: snapshot cleared by reset
        chk_pix("D_128_48", 128, 48, '0);
        chk_pix("D_350_170", 350, 170, '0);
        chk_pix("D_250_340", 250, 340, '0);
        chk_pix("D_488_408", 488, 408, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gol_vga_renderer.md
Name: gol_vga_renderer

Overview:
- Downstream display stage of the Game of Life machine.
- Consumes the registered 256-bit board (16x16, row-major) and renders it on a 640x480@60 VGA monitor as a 16x16 grid of square cells.
- Takes a frame-coherent snapshot of the board once per frame, so a board update never tears mid-frame.
- Sits between the machine top's board output and the FPGA VGA pins. Runs on the 100 MHz board clock with an internal pixel-enable divider.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (100 MHz / 4 = 25 MHz pixel rate).
- CELL_PX, 24, cell edge length in pixels.
- X_ORIGIN, 128, first visible column of the board area.
- Y_ORIGIN, 48, first visible line of the board area.
- ALIVE_COLOR, 12'hFFF, RGB444 colour for a live cell.
- DEAD_COLOR, 12'h000, RGB444 colour for a dead cell and for the area outside the board.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- board_i  in  256  board; bit (row*16+col), row 0 = top, col 0 = left.
- hsync_o  out  1  horizontal sync, active-low.
- vsync_o  out  1  vertical sync, active-low.
- rgb_o  out  12  {R[3:0],G[3:0],B[3:0]}.
- frame_start_o  out  1  one-clk pulse marking the first pixel tick of line 0, pixel 0.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state updates on posedge clk only.
- Reset values:
  - hsync_o=1, vsync_o=1, rgb_o=0, frame_start_o=0.
  - Divider, hcnt, vcnt, cell counters = 0.
  - Snapshot register = 0.
- Pixel tick: a free-running divider 0..CLK_DIV-1; tick = (div==CLK_DIV-1). All counters and outputs update only on a tick.
- Horizontal timing: hcnt 0..799.
  - Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
  - Wrap 799→0 and increment vcnt.
- Vertical timing: vcnt 0..524.
  - Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
  - Wrap 524→0.
- Output latency: outputs are registered from the current hcnt/vcnt on the same tick, so they lag the counters by exactly one pixel tick.
  - hsync_o is low for exactly 96 ticks per 800.
  - vsync_o is low for exactly 2 lines per 525.
- Snapshot: on the tick where hcnt==0 && vcnt==480, capture board_i into the internal snapshot. Changes to board_i at any other time have no visible effect until the next capture.
- Cell addressing: no dividers.
  - px_in_cell counts 0..CELL_PX-1 and cell_x counts 0..15. Both clear when hcnt==X_ORIGIN and advance each tick while inside the board.
  - py_in_cell/cell_y do the same per line, starting at vcnt==Y_ORIGIN.
- Board area: X_ORIGIN ≤ hcnt < X_ORIGIN+16*CELL_PX and Y_ORIGIN ≤ vcnt < Y_ORIGIN+16*CELL_PX.
  - Inside: rgb_o = snapshot[cell_y*16+cell_x] ? ALIVE_COLOR : DEAD_COLOR.
  - Outside the board but visible: DEAD_COLOR.
  - Blanking (hcnt≥640 or vcnt≥480): rgb_o = 0 unconditionally.
- frame_start_o: high for one clk on the tick where hcnt==0 && vcnt==0.
- Reset mid-frame: everything returns to reset values on the next clk edge. The first tick after release is hcnt=0, vcnt=0. The snapshot stays 0 until the next line-480 capture, so the screen is DEAD_COLOR for that first frame.
- Parameter legality: X_ORIGIN+16*CELL_PX ≤ 640 and Y_ORIGIN+16*CELL_PX ≤ 480. Illegal values are out of scope.

Optional Feature:
- Macro: GOL_VGA_GRID_LINES_EN.
- Defined:
  - Inside the board area, a pixel with px_in_cell==0 or py_in_cell==0 is drawn as 12'h444, regardless of cell state.
  - A 1-pixel 12'h444 border is also drawn at hcnt==X_ORIGIN+16*CELL_PX and at vcnt==Y_ORIGIN+16*CELL_PX, within the board span.
- Undefined: no grid or border pixels; cell colour fills the whole cell and the border positions are DEAD_COLOR.

Test Plan:
- Reset → hold reset 10 clks, release → hsync_o/vsync_o=1 and rgb_o=0 during reset; first frame_start_o 1 clk after the first tick; frame_start_o repeats every 800*525*4 = 1,680,000 clks.
- Sync timing → measure over 2 frames → hsync_o low 384 clks of every 3200; vsync_o low 6400 clks of every 1,680,000; both high during reset.
- Single cell → board_i bit 0 =1, others 0, wait for a snapshot → pixels x=128..151, y=48..71 are 12'hFFF, all other visible pixels 12'h000. Bit 255 → x=488..511, y=408..431.
- Coherence → change board_i at vcnt=200 → no rgb_o change until after the line-480 capture; the next frame shows the new board.
- Reset mid-frame → assert reset at vcnt=300 for 1 clk → counters restart at 0,0; snapshot cleared; the whole next frame is 12'h000.
- Grid (GOL_VGA_GRID_LINES_EN defined) → all cells alive → x=128,152,…,488 and x=512 are 12'h444 within y=48..432; pixel (129,49) is 12'hFFF. Macro undefined → (128,48) is 12'hFFF.
